// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state, requester and word types for the SRAM arbiter.
package sram_arb_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 32;

    typedef logic [SRAM_AW-1:0]   SramAddr_t;
    typedef logic [SRAM_DW-1:0]   SramWord_t;
    typedef logic [SRAM_DW/8-1:0] SramBe_t;

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK} SramState_t;
    typedef enum logic {PORT_INST, PORT_DATA} Port_t;

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/sram_arb_sel.sv
// sram_arb_sel: grant selection between instruction and data requesters.
// SRAM_ARB_ROUND_ROBIN_EN gives ties to the port not granted last; otherwise data always wins.
module sram_arb_sel
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic take_i,
    output logic gnt_valid_o,
    output logic gnt_data_o
);

    assign gnt_valid_o = inst_req_i | data_req_i;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    Port_t last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= PORT_INST;
        else if (take_i) last_q <= gnt_data_o ? PORT_DATA : PORT_INST;
    end

    assign gnt_data_o = data_req_i && (!inst_req_i || last_q == PORT_INST);
`else
    logic unused_sel;
    assign unused_sel = clk ^ rst ^ take_i;
    assign gnt_data_o = data_req_i;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between instruction fetch and data ports.
// Define SRAM_ARB_ROUND_ROBIN_EN for alternating grants on ties.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int READ_WAIT   = 2,
    parameter int WRITE_PULSE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_ack,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_ack,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_data_o,
    input  logic [DATA_WIDTH-1:0]   sram_data_i,
    output logic                    sram_data_oe,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic [DATA_WIDTH/8-1:0] sram_be_n
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(max_int(READ_WAIT, WRITE_PULSE)) + 1;
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_WAIT - 1);
    localparam logic [CW-1:0] WP_LOAD = CW'(WRITE_PULSE - 1);

    SramState_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    Port_t                 port_q, port_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BW-1:0]         be_q, be_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                  gnt_valid, gnt_data, take, last_rd, active;

    assign take    = state_q == IDLE && gnt_valid;
    assign last_rd = state_q == RD && cnt_q == '0;

    sram_arb_sel u_sel (
        .clk         (clk),
        .rst         (rst),
        .inst_req_i  (i_req),
        .data_req_i  (d_req),
        .take_i      (take),
        .gnt_valid_o (gnt_valid),
        .gnt_data_o  (gnt_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            port_q    <= PORT_INST;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Phase counter reloads on every state change and saturates at zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = !gnt_valid ? IDLE : (gnt_data && d_we) ? WR_SETUP : RD;
            RD:       state_d = cnt_q == '0 ? ACK : RD;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = cnt_q == '0 ? WR_HOLD : WR_PULSE;
            WR_HOLD:  state_d = ACK;
            ACK:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        cnt_d = state_d != state_q ? (state_d == RD ? RD_LOAD : state_d == WR_PULSE ? WP_LOAD : '0)
              : cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
    end

    always_comb begin
        port_d    = take ? (gnt_data ? PORT_DATA : PORT_INST) : port_q;
        addr_d    = take ? (gnt_data ? d_addr : i_addr) : addr_q;
        wdata_d   = take && gnt_data ? d_wdata : wdata_q;
        be_d      = take ? (gnt_data ? d_be : '1) : be_q;
        i_rdata_d = last_rd && port_q == PORT_INST ? sram_data_i : i_rdata_q;
        d_rdata_d = last_rd && port_q == PORT_DATA ? sram_data_i : d_rdata_q;
    end

    always_comb begin
        active       = state_q inside {RD, WR_SETUP, WR_PULSE, WR_HOLD};
        sram_ce_n    = !active;
        sram_oe_n    = state_q != RD;
        sram_we_n    = state_q != WR_PULSE;
        sram_data_oe = state_q inside {WR_SETUP, WR_PULSE, WR_HOLD};
        sram_be_n    = active ? ~be_q : '1;
        sram_addr    = addr_q;
        sram_data_o  = wdata_q;
        i_ack        = state_q == ACK && port_q == PORT_INST;
        d_ack        = state_q == ACK && port_q == PORT_DATA;
        i_rdata      = i_rdata_q;
        d_rdata      = d_rdata_q;
        busy         = state_q != IDLE;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with a behavioural SRAM.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [19:0] i_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        i_ack, d_ack, busy, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [31:0] i_rdata, d_rdata, sram_data_o, sram_data_i;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;

    always #10 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
        .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
        .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    logic [31:0] mem [0:255];
    assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'h0;

    // SRAM contents are reloaded whenever reset is held
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + i;
            mem[8'h10] <= 32'hDEAD_BEEF;
            mem[8'h20] <= 32'hAAAA_AAAA;
        end else if (!sram_ce_n && !sram_we_n && sram_data_oe) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
        end
    end

    typedef struct {
        logic        is_data;
        logic [31:0] data;
        logic        chk_data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          cyc = 0;
    int          total = 0, passed = 0;
    int          oe_lo = 0, we_lo = 0, be_bad = 0, inv_err = 0, ack_cnt = 0;
    logic [3:0]  exp_be_n = 4'hF;
    logic [19:0] exp_addr = '0;
    logic        pi = 1'b0, pd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!sram_oe_n) oe_lo++;
        if (!sram_we_n) we_lo++;
        if (sram_data_oe && (sram_be_n !== exp_be_n || sram_addr !== exp_addr)) be_bad++;
        if ((!sram_oe_n && !sram_we_n) || (sram_data_oe && !sram_oe_n) ||
            (i_ack && pi) || (d_ack && pd) || (i_ack && d_ack)) inv_err++;
        pi = i_ack;
        pd = d_ack;
        if (i_ack || d_ack) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b at cycle %0d, expected no ack", i_ack, d_ack, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ack_port", {63'h0, d_ack}, {63'h0, e.is_data});
                if (e.chk_data) chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.data);
                chk("ack_cycle", cyc, e.cyc);
            end
        end
    end

    // sel: 0 = instruction ack, 1 = data ack, 2 = either
    task automatic wait_ack(input int sel, input string name);
        int k = 0;
        logic hit = 1'b0;
        while (!hit && k < 40) begin
            @(negedge clk);
            k++;
            hit = sel == 0 ? i_ack : sel == 1 ? d_ack : (i_ack | d_ack);
        end
        if (!hit) begin
            total++;
            $display("FAIL %s_timeout: no ack within %0d cycles, expected ack", name, k);
        end
    endtask

    task automatic d_read(input logic [19:0] a, input logic [31:0] exp);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = a; d_be = 4'hF;
        exp_q.push_back('{1'b1, exp, 1'b1, cyc + 3});
        wait_ack(1, "d_read");
        d_req = 1'b0;
    endtask

    task automatic d_write(input logic [19:0] a, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        exp_be_n = ~be; exp_addr = a;
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = wd; d_be = be;
        exp_q.push_back('{1'b1, 32'h0, 1'b0, cyc + 5});
        wait_ack(1, "d_write");
        d_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        int o, w, a, c;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_data_oe}, 8'b1111_1110);
        chk("rst_busy_acks", {busy, i_ack, d_ack}, 3'b000);
        chk("rst_addr", sram_addr, 20'h0);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        rst = 1'b1;

        o = oe_lo;
        d_read(20'h00010, 32'hDEAD_BEEF);
        chk("read_oe_cycles", oe_lo - o, 2);

        w = we_lo;
        d_write(20'h00020, 32'h1234_5678, 4'b0011);
        chk("write_we_cycles", we_lo - w, 2);
        chk("write_be_addr_stable", be_bad, 0);
        chk("write_mem", mem[8'h20], 32'hAAAA_5678);
        chk("rdata_hold", d_rdata, 32'hDEAD_BEEF);

        // instruction fetch 0..3 back-to-back with i_req held high
        w = we_lo;
        @(negedge clk);
        i_req = 1'b1; i_addr = 20'h0;
        c = cyc;
        for (int n = 0; n < 4; n++) exp_q.push_back('{1'b0, 32'hC0DE_0000 + n, 1'b1, c + 3 + 4 * n});
        for (int n = 0; n < 4; n++) begin
            wait_ack(0, "ifetch");
            i_addr = 20'(n + 1);
        end
        i_req = 1'b0;
        chk("ifetch_no_we", we_lo - w, 0);

        // simultaneous requests: data first, instruction after one idle cycle
        @(negedge clk);
        i_req = 1'b1; i_addr = 20'h3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 20'h10; d_be = 4'hF;
        exp_q.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1, cyc + 3});
        exp_q.push_back('{1'b0, 32'hC0DE_0003, 1'b1, cyc + 7});
        wait_ack(1, "dual_d");
        d_req = 1'b0;
        wait_ack(0, "dual_i");
        i_req = 1'b0;

        // continuous dual requests for four transactions
        @(negedge clk);
        i_req = 1'b1; i_addr = 20'h1;
        d_req = 1'b1; d_addr = 20'h10;
        c = cyc;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_q.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1, c + 3});
        exp_q.push_back('{1'b0, 32'hC0DE_0001, 1'b1, c + 7});
        exp_q.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1, c + 11});
        exp_q.push_back('{1'b0, 32'hC0DE_0001, 1'b1, c + 15});
`else
        for (int n = 0; n < 4; n++) exp_q.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1, c + 3 + 4 * n});
`endif
        for (int n = 0; n < 4; n++) wait_ack(2, "cont_dual");
        i_req = 1'b0; d_req = 1'b0;

        // asynchronous reset in the middle of a write pulse
        @(negedge clk);
        exp_be_n = 4'h0; exp_addr = 20'h30;
        d_req = 1'b1; d_we = 1'b1; d_addr = 20'h30; d_wdata = 32'h5555_AAAA; d_be = 4'hF;
        a = ack_cnt;
        repeat (2) @(negedge clk);
        chk("pre_rst_we_low", {31'h0, sram_we_n}, 32'h0);
        #2 rst = 1'b0;
        #1 chk("rst_async_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_data_oe, busy}, 9'b111_1111_00);
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("rst_no_ack", ack_cnt - a, 0);
        chk("rst_clears_rdata", d_rdata, 32'h0);
        rst = 1'b1;
        d_read(20'h00010, 32'hDEAD_BEEF);

        repeat (3) @(negedge clk);
        chk("invariants", inv_err, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
